// File: rtl/grey_decimal_counter.sv
// 12-digit decimal counter with per-digit 5-bit Johnson codes, parallel load and 7-segment digit display.
// Latency: load/count take effect on the next rising clock edge; display and terminal-count flag are combinational from the digit registers.
// Backpressure: none; the counter accepts load/count every cycle and outputs are always valid.
//
// Ports:
//   io_in[0]   clk, rising-edge
//   io_in[1]   rst_n, asynchronous active-low clear of all digits
//   io_in[7:2] sel: [3:0] display digit select (12..15 blank), [4] count enable, [5] load (wins over count)
//   init       60-bit load value, digit i at [5i+4:5i]
//   ones..hunB registered Johnson code of digits 0..11
//   io_out     [6:0] 7-segment (a=bit0) of selected digit, [7] all-nines terminal-count flag
// Build option: GREY_SATURATE_EN makes the counter hold at all nines instead of wrapping to zero.

module grey_decimal_counter (
    input  logic [7:0]  io_in,
    input  logic [59:0] init,
    output logic [4:0]  ones,
    output logic [4:0]  tens,
    output logic [4:0]  hund,
    output logic [4:0]  thou,
    output logic [4:0]  tenT,
    output logic [4:0]  hunT,
    output logic [4:0]  mil,
    output logic [4:0]  tenM,
    output logic [4:0]  hunM,
    output logic [4:0]  bil,
    output logic [4:0]  tenB,
    output logic [4:0]  hunB,
    output logic [7:0]  io_out
);

    localparam logic [4:0] CODE_NINE = 5'b10000;

    logic       clk;
    logic       rst_n;
    logic [3:0] disp_sel;
    logic       cnt_en;
    logic       load_en;

    assign clk      = io_in[0];
    assign rst_n    = io_in[1];
    assign disp_sel = io_in[5:2];
    assign cnt_en   = io_in[6];
    assign load_en  = io_in[7];

    logic [11:0][4:0] digit_q;
    logic [11:0][4:0] digit_d;
    logic             all_nine;
    logic             hold_sat;
    logic [4:0]       disp_code;
    logic [6:0]       disp_seg;

    // Only the ten Johnson patterns of a decimal digit are legal.
    function automatic logic is_valid(input logic [4:0] code);
        case (code)
            5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
            5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000: is_valid = 1'b1;
            default:                                          is_valid = 1'b0;
        endcase
    endfunction

    function automatic logic [6:0] seg_of(input logic [4:0] code);
        case (code)
            5'b00000: seg_of = 7'h3F;
            5'b00001: seg_of = 7'h06;
            5'b00011: seg_of = 7'h5B;
            5'b00111: seg_of = 7'h4F;
            5'b01111: seg_of = 7'h66;
            5'b11111: seg_of = 7'h6D;
            5'b11110: seg_of = 7'h7D;
            5'b11100: seg_of = 7'h07;
            5'b11000: seg_of = 7'h7F;
            5'b10000: seg_of = 7'h6F;
            default:  seg_of = 7'h40;  // dash for an illegal pattern
        endcase
    endfunction

    // Incremented value. The carry into digit i is "every lower digit holds 9";
    // an illegal digit that is due to step is scrubbed to zero and never carries.
    always_comb begin
        logic carry;
        carry   = 1'b1;
        digit_d = digit_q;
        for (int i = 0; i < 12; i++) begin
            if (carry) begin
                if (is_valid(digit_q[i])) begin
                    digit_d[i] = {digit_q[i][3:0], ~digit_q[i][4]};
                end else begin
                    digit_d[i] = 5'b00000;
                end
            end
            carry = carry && (digit_q[i] == CODE_NINE);
        end
    end

    always_comb begin
        all_nine = 1'b1;
        for (int i = 0; i < 12; i++) begin
            all_nine = all_nine && (digit_q[i] == CODE_NINE);
        end
    end

`ifdef GREY_SATURATE_EN
    assign hold_sat = all_nine;
`else
    assign hold_sat = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else if (load_en) begin
            digit_q <= init;
        end else if (cnt_en && !hold_sat) begin
            digit_q <= digit_d;
        end
    end

    always_comb begin
        disp_code = 5'b00000;
        case (disp_sel)
            4'd0:    disp_code = digit_q[0];
            4'd1:    disp_code = digit_q[1];
            4'd2:    disp_code = digit_q[2];
            4'd3:    disp_code = digit_q[3];
            4'd4:    disp_code = digit_q[4];
            4'd5:    disp_code = digit_q[5];
            4'd6:    disp_code = digit_q[6];
            4'd7:    disp_code = digit_q[7];
            4'd8:    disp_code = digit_q[8];
            4'd9:    disp_code = digit_q[9];
            4'd10:   disp_code = digit_q[10];
            4'd11:   disp_code = digit_q[11];
            default: disp_code = 5'b00000;
        endcase
    end

    // Selects 12..15 blank the display rather than showing a digit.
    assign disp_seg = (disp_sel > 4'd11) ? 7'h00 : seg_of(disp_code);
    assign io_out   = {all_nine, disp_seg};

    assign ones = digit_q[0];
    assign tens = digit_q[1];
    assign hund = digit_q[2];
    assign thou = digit_q[3];
    assign tenT = digit_q[4];
    assign hunT = digit_q[5];
    assign mil  = digit_q[6];
    assign tenM = digit_q[7];
    assign hunM = digit_q[8];
    assign bil  = digit_q[9];
    assign tenB = digit_q[10];
    assign hunB = digit_q[11];

endmodule

// File: tb/tb_grey_decimal_counter.sv
// Directed-vector bench for grey_decimal_counter.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable.

module tb_grey_decimal_counter;

    localparam logic [4:0] JC [0:9] = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
                                        5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000};
    localparam logic [6:0] SEG [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic        clk;
    logic        rst_n;
    logic [3:0]  dsel;
    logic        cnt_en;
    logic        load_en;
    logic [7:0]  io_in;
    logic [59:0] init;
    logic [4:0]  ones, tens, hund, thou, tenT, hunT, mil, tenM, hunM, bil, tenB, hunB;
    logic [7:0]  io_out;
    logic [59:0] all_q;

    int n_checks = 0;
    int n_errs   = 0;

    assign io_in = {load_en, cnt_en, dsel, rst_n, clk};
    assign all_q = {hunB, tenB, bil, hunM, tenM, mil, hunT, tenT, thou, hund, tens, ones};

    grey_decimal_counter dut (
        .io_in  (io_in),
        .init   (init),
        .ones   (ones),
        .tens   (tens),
        .hund   (hund),
        .thou   (thou),
        .tenT   (tenT),
        .hunT   (hunT),
        .mil    (mil),
        .tenM   (tenM),
        .hunM   (hunM),
        .bil    (bil),
        .tenB   (tenB),
        .hunB   (hunB),
        .io_out (io_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        dsel    = 4'd0;
        cnt_en  = 1'b0;
        load_en = 1'b0;
        init    = '0;
        tick();
        tick();
        check_val("reset_digits", all_q, 60'h0);
        check_val("reset_disp0", io_out, 8'h3F);
        dsel = 4'd15;
        #1;
        check_val("reset_blank", io_out, 8'h00);
        dsel = 4'd0;

        // Count 0..10 from reset
        rst_n  = 1'b1;
        cnt_en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_val($sformatf("count_ones_%0d", k), ones, JC[k % 10]);
            check_val($sformatf("count_seg_%0d", k), io_out[6:0], SEG[k % 10]);
        end
        check_val("count_tens", tens, JC[1]);

        // Asynchronous reset mid-count, no edge needed
        tick();
        tick();
        tick();
        check_val("pre_reset_13", all_q, {{10{5'b00000}}, JC[1], JC[3]});
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_clear", all_q, 60'h0);
        check_val("async_disp", io_out, 8'h3F);
        load_en = 1'b1;
        init    = {12{5'b10000}};
        tick();
        check_val("reset_dominates", all_q, 60'h0);
        rst_n   = 1'b1;
        load_en = 1'b0;
        cnt_en  = 1'b0;

        // Load 000000099999 then ripple
        init    = {{7{5'b00000}}, {5{5'b10000}}};
        load_en = 1'b1;
        tick();
        check_val("load_99999", all_q, {{7{5'b00000}}, {5{5'b10000}}});
        load_en = 1'b0;
        cnt_en  = 1'b1;
        tick();
        cnt_en = 1'b0;
        check_val("ripple_100000", all_q, {{6{5'b00000}}, 5'b00001, {5{5'b00000}}});
        dsel = 4'd5;
        #1;
        check_val("ripple_disp5", io_out, 8'h06);
        tick();
        check_val("hold", all_q, {{6{5'b00000}}, 5'b00001, {5{5'b00000}}});

        // All nines: flag, then wrap or saturate
        dsel    = 4'd0;
        init    = {12{5'b10000}};
        load_en = 1'b1;
        tick();
        load_en = 1'b0;
        check_val("nines_flag", io_out, 8'hEF);
        cnt_en = 1'b1;
        tick();
        cnt_en = 1'b0;
`ifdef GREY_SATURATE_EN
        check_val("sat_digits", all_q, {12{5'b10000}});
        check_val("sat_flag", io_out[7], 1'b1);
`else
        check_val("wrap_digits", all_q, 60'h0);
        check_val("wrap_flag", io_out, 8'h3F);
`endif

        // Illegal ones pattern
        init    = {{10{5'b00000}}, 5'b00011, 5'b01010};
        load_en = 1'b1;
        tick();
        load_en = 1'b0;
        check_val("invalid_load", all_q, {{10{5'b00000}}, 5'b00011, 5'b01010});
        check_val("invalid_dash", io_out, 8'h40);
        cnt_en = 1'b1;
        tick();
        cnt_en = 1'b0;
        check_val("invalid_scrub", all_q, {{10{5'b00000}}, 5'b00011, 5'b00000});
        check_val("invalid_scrub_disp", io_out, 8'h3F);

        // Mux select and load-over-count priority
        init    = {5'b11100, {10{5'b00000}}, 5'b00111};
        load_en = 1'b1;
        cnt_en  = 1'b1;
        tick();
        load_en = 1'b0;
        cnt_en  = 1'b0;
        check_val("load_beats_count", all_q, {5'b11100, {10{5'b00000}}, 5'b00111});
        check_val("disp_ones_3", io_out, 8'h4F);
        dsel = 4'd11;
        #1;
        check_val("disp_hunB_7", io_out, 8'h07);
        dsel = 4'd13;
        #1;
        check_val("disp_blank_13", io_out, 8'h00);
        dsel = 4'd12;
        #1;
        check_val("disp_blank_12", io_out, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
